// File: rtl/jtag_ir_ctrl.sv
// JTAG instruction register: capture/shift/update stages, TLR handling and a protocol tracker.
// Optional JTAG_IR_STATUS_CAPTURE_EN adds status_in, loaded into the upper bits on Capture-IR.
module jtag_ir_ctrl #(
    parameter int                  IR_WIDTH    = 4,
    parameter logic [IR_WIDTH-1:0] RESET_INSTR = 'h1,
    parameter int                  CNT_W       = 6
) (
    input  logic                iclk,
    input  logic                reset,
    input  logic                tlr,
    input  logic                capture_ir,
    input  logic                shift_ir,
    input  logic                update_ir,
    input  logic                tdi,
`ifdef JTAG_IR_STATUS_CAPTURE_EN
    input  logic [IR_WIDTH-3:0] status_in,
`endif
    output logic                tdo,
    output logic [IR_WIDTH-1:0] instr,
    output logic                instr_valid,
    output logic [CNT_W-1:0]    shift_cnt,
    output logic                len_err,
    output logic                seq_err
);

    // state     | meaning
    // IDLE      | no capture since the last update / reset / TLR
    // CAPTURED  | capture seen, nothing shifted yet
    // SHIFTING  | at least one bit shifted since the capture
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CAPTURED = 2'd1,
        ST_SHIFTING = 2'd2
    } state_t;

    localparam logic [IR_WIDTH-1:0] IR_BASE = IR_WIDTH'(2'b01);

    state_t              state;
    logic [IR_WIDTH-1:0] shift_reg;
    logic [IR_WIDTH-1:0] capture_val;

`ifdef JTAG_IR_STATUS_CAPTURE_EN
    assign capture_val = {status_in, 2'b01};
`else
    assign capture_val = IR_BASE;
`endif

    assign tdo = shift_reg[0];

    always_ff @(posedge iclk) begin
        if (reset) begin
            state       <= ST_IDLE;
            shift_reg   <= IR_BASE;
            instr       <= RESET_INSTR;
            instr_valid <= 1'b0;
            shift_cnt   <= '0;
            len_err     <= 1'b0;
            seq_err     <= 1'b0;
        end else if (tlr) begin
            // Same as reset, but the error flags survive for post-mortem reads.
            state       <= ST_IDLE;
            shift_reg   <= IR_BASE;
            instr       <= RESET_INSTR;
            instr_valid <= 1'b0;
            shift_cnt   <= '0;
        end else begin
            instr_valid <= update_ir;
            if (update_ir) begin
                instr   <= shift_reg;
                len_err <= (32'(shift_cnt) != IR_WIDTH);
                if (state == ST_IDLE) begin
                    seq_err <= 1'b1;
                end
            end
            if (capture_ir) begin
                shift_reg <= capture_val;
                shift_cnt <= '0;
                state     <= ST_CAPTURED;
            end else begin
                if (shift_ir) begin
                    shift_reg <= {tdi, shift_reg[IR_WIDTH-1:1]};
                    if (shift_cnt != '1) begin
                        shift_cnt <= shift_cnt + CNT_W'(1);
                    end
                end
                if (update_ir) begin
                    state <= ST_IDLE;
                end else if (shift_ir && state == ST_CAPTURED) begin
                    state <= ST_SHIFTING;
                end
            end
        end
    end

endmodule

// File: tb/tb_jtag_ir_ctrl.sv
// Self-checking bench for jtag_ir_ctrl (IR_WIDTH=4, RESET_INSTR=4'h1): directed scenarios
// followed by randomized strobes compared against a behavioural model.
module tb_jtag_ir_ctrl;

    localparam int W     = 4;
    localparam int CNT_W = 6;

    logic             iclk = 1'b0;
    logic             reset, tlr, capture_ir, shift_ir, update_ir, tdi;
    logic [W-3:0]     status_in;
    logic             tdo;
    logic [W-1:0]     instr;
    logic             instr_valid;
    logic [CNT_W-1:0] shift_cnt;
    logic             len_err, seq_err;

    int n_cmp  = 0;
    int n_fail = 0;

    int unsigned m_sr, m_instr, m_cnt;
    bit          m_valid, m_len, m_seq, m_capd;

    jtag_ir_ctrl #(.IR_WIDTH(W), .RESET_INSTR(4'h1), .CNT_W(CNT_W)) dut (
        .iclk        (iclk),
        .reset       (reset),
        .tlr         (tlr),
        .capture_ir  (capture_ir),
        .shift_ir    (shift_ir),
        .update_ir   (update_ir),
        .tdi         (tdi),
`ifdef JTAG_IR_STATUS_CAPTURE_EN
        .status_in   (status_in),
`endif
        .tdo         (tdo),
        .instr       (instr),
        .instr_valid (instr_valid),
        .shift_cnt   (shift_cnt),
        .len_err     (len_err),
        .seq_err     (seq_err)
    );

    always #5 iclk = ~iclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned cap_value();
`ifdef JTAG_IR_STATUS_CAPTURE_EN
        return (int'(status_in) << 2) | 1;
`else
        return 1;
`endif
    endfunction

    // Reference: the IR as an integer, "capture seen since last update" as a flag.
    task automatic model_step(input bit r, input bit t, input bit c, input bit s, input bit u, input bit d);
        int unsigned old_sr, old_cnt;
        if (r || t) begin
            m_sr = 1; m_instr = 1; m_valid = 0; m_cnt = 0; m_capd = 0;
            if (r) begin m_len = 0; m_seq = 0; end
            return;
        end
        old_sr  = m_sr;
        old_cnt = m_cnt;
        m_valid = u;
        if (u) begin
            m_instr = old_sr;
            m_len   = (old_cnt != W);
            if (!m_capd) m_seq = 1;
            m_capd  = 0;
        end
        if (c) begin
            m_sr = cap_value(); m_cnt = 0; m_capd = 1;
        end else if (s) begin
            m_sr  = (old_sr >> 1) | (int'(d) << (W - 1));
            m_cnt = (old_cnt == (1 << CNT_W) - 1) ? old_cnt : old_cnt + 1;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ":tdo"},       32'(tdo),         32'(m_sr & 1));
        chk({tag, ":instr"},     32'(instr),       m_instr);
        chk({tag, ":valid"},     32'(instr_valid), 32'(m_valid));
        chk({tag, ":shift_cnt"}, 32'(shift_cnt),   m_cnt);
        chk({tag, ":len_err"},   32'(len_err),     32'(m_len));
        chk({tag, ":seq_err"},   32'(seq_err),     32'(m_seq));
    endtask

    task automatic cycle(input string tag, input bit r, input bit t, input bit c,
                         input bit s, input bit u, input bit d);
        reset = r; tlr = t; capture_ir = c; shift_ir = s; update_ir = u; tdi = d;
        @(posedge iclk);
        model_step(r, t, c, s, u, d);
        #1;
        check_all(tag);
    endtask

    initial begin
        reset = 1; tlr = 0; capture_ir = 0; shift_ir = 0; update_ir = 0; tdi = 0;
        status_in = 2'b10;

        cycle("rst0", 1, 0, 0, 0, 0, 0);
        cycle("rst1", 1, 0, 0, 0, 0, 0);
        chk("rst_instr", 32'(instr), 32'h1);
        chk("rst_tdo", 32'(tdo), 32'h1);
        chk("rst_cnt", 32'(shift_cnt), 32'h0);

        // Capture, shift 0,1,0,1, update -> 4'hA
        cycle("capA", 0, 0, 1, 0, 0, 0);
        chk("capA_tdo", 32'(tdo), 32'h1);
        cycle("shA0", 0, 0, 0, 1, 0, 0);
        cycle("shA1", 0, 0, 0, 1, 0, 1);
        cycle("shA2", 0, 0, 0, 1, 0, 0);
        cycle("shA3", 0, 0, 0, 1, 0, 1);
        chk("shA_tdo", 32'(tdo), 32'h0);
        cycle("updA", 0, 0, 0, 0, 1, 0);
        chk("updA_instr", 32'(instr), 32'hA);
        chk("updA_valid", 32'(instr_valid), 32'h1);
        chk("updA_len", 32'(len_err), 32'h0);
        cycle("postA", 0, 0, 0, 0, 0, 0);
        chk("postA_valid", 32'(instr_valid), 32'h0);

        // Over-long shift -> len_err
        cycle("capF", 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle("shF", 0, 0, 0, 1, 0, 1);
        chk("shF_cnt", 32'(shift_cnt), 32'd5);
        cycle("updF", 0, 0, 0, 0, 1, 0);
        chk("updF_instr", 32'(instr), 32'hF);
        chk("updF_len", 32'(len_err), 32'h1);

        // Update without capture after reset -> seq_err
        cycle("rst2", 1, 0, 0, 0, 0, 0);
        cycle("updNC", 0, 0, 0, 0, 1, 0);
        chk("updNC_instr", 32'(instr), 32'h1);
        chk("updNC_seq", 32'(seq_err), 32'h1);

        // Load 4'hA, then TLR mid-shift
        cycle("capB", 0, 0, 1, 0, 0, 0);
        cycle("shB0", 0, 0, 0, 1, 0, 0);
        cycle("shB1", 0, 0, 0, 1, 0, 1);
        cycle("shB2", 0, 0, 0, 1, 0, 0);
        cycle("shB3", 0, 0, 0, 1, 0, 1);
        cycle("updB", 0, 0, 0, 0, 1, 0);
        cycle("capC", 0, 0, 1, 0, 0, 0);
        cycle("shC0", 0, 0, 0, 1, 0, 1);
        cycle("tlr",  0, 1, 0, 1, 0, 1);
        chk("tlr_instr", 32'(instr), 32'h1);
        chk("tlr_cnt", 32'(shift_cnt), 32'h0);
        chk("tlr_seq_held", 32'(seq_err), 32'h1);

        // Capture and shift in the same cycle: shift dropped
        cycle("capsh", 0, 0, 1, 1, 0, 1);
        chk("capsh_cnt", 32'(shift_cnt), 32'h0);
        chk("capsh_tdo", 32'(tdo), 32'h1);

        // Combined strobes and counter saturation
        cycle("updcap", 0, 0, 1, 0, 1, 0);
        cycle("updsh", 0, 0, 0, 1, 1, 1);
        cycle("capS", 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 70; i++) cycle("sat", 0, 0, 0, 1, 0, i[0]);
        chk("sat_cnt", 32'(shift_cnt), 32'd63);

        // Randomized strobes
        for (int i = 0; i < 600; i++) begin
            bit r, t, c, s, u;
            r = ($urandom_range(0, 99) < 2);
            t = ($urandom_range(0, 99) < 3);
            c = ($urandom_range(0, 99) < 15);
            s = ($urandom_range(0, 99) < 60);
            u = ($urandom_range(0, 99) < 15);
            status_in = 2'($urandom);
            cycle("rand", r, t, c, s, u, 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
